// File: rtl/noc_link_pkg.sv
// Shared constants and helpers for the NoC link relay stage and its FIFO.
package noc_link_pkg;

    localparam int FLIT_WIDTH_DEF   = 64;
    localparam int DEST_WIDTH_DEF   = 6;
    localparam int OUT_PIPELINE_MAX = 4;

    // Width needed to hold any value 0..max(a,b) inclusive.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/noc_link_fifo.sv
// Synchronous FIFO for the link relay; accepts a push while full when a pop happens in the same cycle.
module noc_link_fifo
    import noc_link_pkg::*;
#(
    parameter int WIDTH     = 71,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        full_s    = 1'b0;
        empty_s   = 1'b0;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        full_s    = (count_r == CNT_WIDTH'(DEPTH));
        empty_s   = (count_r == {CNT_WIDTH{1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and fill count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/noc_link_relay.sv
// Credit-terminating relay on a router-to-router link: buffers flits, returns upstream
// credits on dequeue, and tracks its own credits toward the downstream router.
module noc_link_relay
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH         = FLIT_WIDTH_DEF,
    parameter int DEST_WIDTH         = DEST_WIDTH_DEF,
    parameter int BUFFER_DEPTH       = 8,
    parameter int DOWNSTREAM_CREDITS = 8,
    parameter int OUT_PIPELINE       = 0,
    parameter int CNT_WIDTH          = cnt_width(BUFFER_DEPTH, DOWNSTREAM_CREDITS)
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic [CNT_WIDTH-1:0]  credit_count,
    output logic                  overflow_err,
    output logic                  credit_err
);

    localparam int ENTRY_W = 1 + DEST_WIDTH + FLIT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(DOWNSTREAM_CREDITS);

    logic [ENTRY_W-1:0]    head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_WIDTH-1:0]  fifo_count_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    logic [CNT_WIDTH-1:0]  credit_count_r;
    logic                  credit_out_r;
    logic                  overflow_err_r;
    logic                  credit_err_r;

    // Index 0 is the output register; higher indices are the optional retiming stages.
    logic [OUT_PIPELINE:0] pipe_send_r;
    logic                  pipe_tail_r [OUT_PIPELINE+1];
    logic [DEST_WIDTH-1:0] pipe_dest_r [OUT_PIPELINE+1];
    logic [FLIT_WIDTH-1:0] pipe_data_r [OUT_PIPELINE+1];

    // Pop whenever a flit and a downstream credit are both available; accept when room exists.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        pop_s  = !fifo_empty_s && (credit_count_r != {CNT_WIDTH{1'b0}});
        push_s = send_in && (!fifo_full_s || pop_s);
        drop_s = send_in && !push_s;
    end

    noc_link_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (BUFFER_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk_noc),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({is_tail_in, dest_in, data_in}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Downstream credit counter; a credit arriving while already full saturates and flags.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            credit_count_r <= CREDIT_MAX;
            credit_err_r   <= 1'b0;
        end else begin
            case ({credit_in, pop_s})
                2'b10: begin
                    if (credit_count_r == CREDIT_MAX) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credit_count_r <= credit_count_r + CNT_WIDTH'(1);
                    end
                end
                2'b01:   credit_count_r <= credit_count_r - CNT_WIDTH'(1);
                default: credit_count_r <= credit_count_r;
            endcase
        end
    end

    // Upstream credit strobe and sticky overflow flag.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            credit_out_r   <= 1'b0;
            overflow_err_r <= 1'b0;
        end else begin
            credit_out_r <= pop_s;
            if (drop_s) begin
                overflow_err_r <= 1'b1;
            end
        end
    end

    // Output register plus free-running shift pipeline; fields hold when no flit is loaded.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            for (int i = 0; i <= OUT_PIPELINE; i++) begin
                pipe_send_r[i] <= 1'b0;
                pipe_tail_r[i] <= 1'b0;
                pipe_dest_r[i] <= {DEST_WIDTH{1'b0}};
                pipe_data_r[i] <= {FLIT_WIDTH{1'b0}};
            end
        end else begin
            pipe_send_r[0] <= pop_s;
            if (pop_s) begin
                {pipe_tail_r[0], pipe_dest_r[0], pipe_data_r[0]} <= head_s;
            end
            for (int i = 1; i <= OUT_PIPELINE; i++) begin
                pipe_send_r[i] <= pipe_send_r[i-1];
                pipe_tail_r[i] <= pipe_tail_r[i-1];
                pipe_dest_r[i] <= pipe_dest_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    assign send_out     = pipe_send_r[OUT_PIPELINE];
    assign is_tail_out  = pipe_tail_r[OUT_PIPELINE];
    assign dest_out     = pipe_dest_r[OUT_PIPELINE];
    assign data_out     = pipe_data_r[OUT_PIPELINE];
    assign credit_out   = credit_out_r;
    assign occupancy    = fifo_count_s;
    assign credit_count = credit_count_r;
    assign overflow_err = overflow_err_r;
    assign credit_err   = credit_err_r;

endmodule

// File: tb/tb_noc_link_relay.sv
// Directed self-checking bench: one relay with OUT_PIPELINE=0 and one with OUT_PIPELINE=2 share stimulus.
module tb_noc_link_relay;

    logic        clk_noc = 1'b0;
    logic        rst_n;
    logic [63:0] data_in;
    logic [5:0]  dest_in;
    logic        is_tail_in;
    logic        send_in;
    logic        credit_in;

    logic        credit_out_0, is_tail_out_0, send_out_0, overflow_err_0, credit_err_0;
    logic [63:0] data_out_0;
    logic [5:0]  dest_out_0;
    logic [3:0]  occupancy_0, credit_count_0;

    logic        credit_out_2, is_tail_out_2, send_out_2, overflow_err_2, credit_err_2;
    logic [63:0] data_out_2;
    logic [5:0]  dest_out_2;
    logic [3:0]  occupancy_2, credit_count_2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_noc = ~clk_noc;

    noc_link_relay #(.OUT_PIPELINE(0)) u0 (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_0),
        .data_out(data_out_0), .dest_out(dest_out_0), .is_tail_out(is_tail_out_0),
        .send_out(send_out_0), .credit_in(credit_in), .occupancy(occupancy_0),
        .credit_count(credit_count_0), .overflow_err(overflow_err_0), .credit_err(credit_err_0)
    );

    noc_link_relay #(.OUT_PIPELINE(2)) u2 (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_2),
        .data_out(data_out_2), .dest_out(dest_out_2), .is_tail_out(is_tail_out_2),
        .send_out(send_out_2), .credit_in(credit_in), .occupancy(occupancy_2),
        .credit_count(credit_count_2), .overflow_err(overflow_err_2), .credit_err(credit_err_2)
    );

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; send_in = 1'b0; credit_in = 1'b0;
        data_in = 64'h0; dest_in = 6'h0; is_tail_in = 1'b0;
        tick();
        n_checks++;
        if ({send_out_0, credit_out_0, is_tail_out_0, overflow_err_0, credit_err_0} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags0: got %b expected 00000",
                {send_out_0, credit_out_0, is_tail_out_0, overflow_err_0, credit_err_0});
        end
        n_checks++;
        if ({data_out_0, dest_out_0} !== 70'h0) begin
            n_fail++; $display("FAIL reset_data0: got %h/%h expected 0/0", data_out_0, dest_out_0);
        end
        n_checks++;
        if (occupancy_0 !== 4'd0 || credit_count_0 !== 4'd8) begin
            n_fail++; $display("FAIL reset_cnt0: got occ=%0d cred=%0d expected 0/8", occupancy_0, credit_count_0);
        end
        n_checks++;
        if ({send_out_2, credit_out_2, overflow_err_2, credit_err_2} !== 4'b0 ||
            occupancy_2 !== 4'd0 || credit_count_2 !== 4'd8 || data_out_2 !== 64'h0) begin
            n_fail++; $display("FAIL reset_u2: got send=%b cr=%b occ=%0d cred=%0d data=%h expected 0/0/0/8/0",
                send_out_2, credit_out_2, occupancy_2, credit_count_2, data_out_2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        send_in = 1'b1; data_in = 64'hA5A5_0000_0000_0001; dest_in = 6'h0B; is_tail_in = 1'b1;
        tick();
        send_in = 1'b0; is_tail_in = 1'b0; dest_in = 6'h0; data_in = 64'h0;
        n_checks++;
        if (send_out_0 !== 1'b0) begin
            n_fail++; $display("FAIL single_early: got send_out=%b expected 0", send_out_0);
        end
        tick();
        n_checks++;
        if (send_out_0 !== 1'b1 || credit_out_0 !== 1'b1) begin
            n_fail++; $display("FAIL single_strobes: got send=%b credit=%b expected 1/1", send_out_0, credit_out_0);
        end
        n_checks++;
        if (data_out_0 !== 64'hA5A5_0000_0000_0001 || dest_out_0 !== 6'h0B || is_tail_out_0 !== 1'b1) begin
            n_fail++; $display("FAIL single_fields: got %h/%h/%b expected a5a5000000000001/0b/1",
                data_out_0, dest_out_0, is_tail_out_0);
        end
        n_checks++;
        if (credit_count_0 !== 4'd7) begin
            n_fail++; $display("FAIL single_credit: got %0d expected 7", credit_count_0);
        end
        tick();
        n_checks++;
        if (send_out_0 !== 1'b0 || credit_out_0 !== 1'b0 || data_out_0 !== 64'hA5A5_0000_0000_0001) begin
            n_fail++; $display("FAIL single_hold: got send=%b credit=%b data=%h expected 0/0/held",
                send_out_0, credit_out_0, data_out_0);
        end
    endtask

    task automatic test_credit_exhaustion();
        int sends = 0;
        int creds = 0;
        int next_exp = 0;
        for (int i = 0; i < 18; i++) begin
            send_in = (i < 12); data_in = 64'(i);
            tick();
            if (send_out_0) begin
                sends++;
                n_checks++;
                if (data_out_0 !== 64'(next_exp)) begin
                    n_fail++; $display("FAIL exhaust_order: got %h expected %h", data_out_0, 64'(next_exp));
                end
                next_exp++;
            end
            if (credit_out_0) creds++;
        end
        send_in = 1'b0;
        n_checks++;
        if (sends != 8 || creds != 8) begin
            n_fail++; $display("FAIL exhaust_counts: got sends=%0d credits=%0d expected 8/8", sends, creds);
        end
        n_checks++;
        if (occupancy_0 !== 4'd4 || credit_count_0 !== 4'd0) begin
            n_fail++; $display("FAIL exhaust_state: got occ=%0d cred=%0d expected 4/0", occupancy_0, credit_count_0);
        end
        for (int i = 0; i < 10; i++) begin
            credit_in = (i < 4);
            tick();
            if (send_out_0) begin
                sends++;
                n_checks++;
                if (data_out_0 !== 64'(next_exp)) begin
                    n_fail++; $display("FAIL drain_order: got %h expected %h", data_out_0, 64'(next_exp));
                end
                next_exp++;
            end
        end
        credit_in = 1'b0;
        n_checks++;
        if (sends != 12 || occupancy_0 !== 4'd0 || credit_count_0 !== 4'd0) begin
            n_fail++; $display("FAIL drain_state: got sends=%0d occ=%0d cred=%0d expected 12/0/0",
                sends, occupancy_0, credit_count_0);
        end
    endtask

    task automatic test_overflow();
        int creds = 0;
        int sends = 0;
        int next_exp = 100;
        for (int i = 0; i < 8; i++) begin
            send_in = 1'b1; data_in = 64'(100 + i);
            tick();
            if (credit_out_0) creds++;
        end
        n_checks++;
        if (occupancy_0 !== 4'd8 || creds != 0 || overflow_err_0 !== 1'b0) begin
            n_fail++; $display("FAIL fill_state: got occ=%0d credits=%0d ovf=%b expected 8/0/0",
                occupancy_0, creds, overflow_err_0);
        end
        data_in = 64'hDEAD;
        tick();
        send_in = 1'b0;
        n_checks++;
        if (overflow_err_0 !== 1'b1 || occupancy_0 !== 4'd8 || credit_out_0 !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got ovf=%b occ=%0d credit=%b expected 1/8/0",
                overflow_err_0, occupancy_0, credit_out_0);
        end
        for (int i = 0; i < 14; i++) begin
            credit_in = (i < 8);
            tick();
            if (send_out_0) begin
                sends++;
                n_checks++;
                if (data_out_0 !== 64'(next_exp)) begin
                    n_fail++; $display("FAIL overflow_order: got %h expected %h", data_out_0, 64'(next_exp));
                end
                next_exp++;
            end
        end
        credit_in = 1'b0;
        n_checks++;
        if (sends != 8 || occupancy_0 !== 4'd0 || overflow_err_0 !== 1'b1) begin
            n_fail++; $display("FAIL overflow_drain: got sends=%0d occ=%0d ovf=%b expected 8/0/1",
                sends, occupancy_0, overflow_err_0);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 11; i++) begin
            send_in = (i < 7); data_in = 64'(i);
            tick();
        end
        n_checks++;
        if (credit_count_0 !== 4'd1 || occupancy_0 !== 4'd0) begin
            n_fail++; $display("FAIL simul_setup: got cred=%0d occ=%0d expected 1/0", credit_count_0, occupancy_0);
        end
        send_in = 1'b1; data_in = 64'h5151;
        tick();
        data_in = 64'h5252; credit_in = 1'b1;
        tick();
        send_in = 1'b0; credit_in = 1'b0;
        n_checks++;
        if (credit_count_0 !== 4'd1 || send_out_0 !== 1'b1 || data_out_0 !== 64'h5151) begin
            n_fail++; $display("FAIL simul_both: got cred=%0d send=%b data=%h expected 1/1/5151",
                credit_count_0, send_out_0, data_out_0);
        end
        tick();
        n_checks++;
        if (send_out_0 !== 1'b1 || data_out_0 !== 64'h5252 || credit_count_0 !== 4'd0 || credit_err_0 !== 1'b0) begin
            n_fail++; $display("FAIL simul_next: got send=%b data=%h cred=%0d cerr=%b expected 1/5252/0/0",
                send_out_0, data_out_0, credit_count_0, credit_err_0);
        end
    endtask

    task automatic test_credit_err();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        n_checks++;
        if (credit_err_0 !== 1'b1 || credit_count_0 !== 4'd8) begin
            n_fail++; $display("FAIL credit_err: got cerr=%b cred=%0d expected 1/8", credit_err_0, credit_count_0);
        end
        tick();
        tick();
        n_checks++;
        if (credit_err_0 !== 1'b1) begin
            n_fail++; $display("FAIL credit_err_sticky: got %b expected 1", credit_err_0);
        end
    endtask

    task automatic test_pipeline();
        int total = 0;
        int run = 0;
        int max_run = 0;
        int next_exp = 32'h100;
        send_in = 1'b1; data_in = 64'hCAFE; dest_in = 6'h21; is_tail_in = 1'b0;
        tick();
        send_in = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            n_checks++;
            if (send_out_2 !== 1'b0) begin
                n_fail++; $display("FAIL pipe_early: cycle +%0d got send_out=%b expected 0", k - 1, send_out_2);
            end
            tick();
        end
        n_checks++;
        if (send_out_2 !== 1'b1 || data_out_2 !== 64'hCAFE || dest_out_2 !== 6'h21) begin
            n_fail++; $display("FAIL pipe_latency: got send=%b data=%h dest=%h expected 1/cafe/21",
                send_out_2, data_out_2, dest_out_2);
        end
        test_reset();
        for (int i = 0; i < 40; i++) begin
            send_in = (i < 16); data_in = 64'(32'h100 + i);
            tick();
            if (send_out_2) begin
                total++; run++;
                if (run > max_run) max_run = run;
                n_checks++;
                if (data_out_2 !== 64'(next_exp)) begin
                    n_fail++; $display("FAIL burst_order: got %h expected %h", data_out_2, 64'(next_exp));
                end
                next_exp++;
            end else begin
                run = 0;
            end
            credit_in = send_out_2;
        end
        credit_in = 1'b0;
        n_checks++;
        if (total != 16 || max_run != 16) begin
            n_fail++; $display("FAIL burst_rate: got total=%0d run=%0d expected 16/16", total, max_run);
        end
        n_checks++;
        if (credit_count_2 !== 4'd8 || credit_err_2 !== 1'b0 || occupancy_2 !== 4'd0) begin
            n_fail++; $display("FAIL burst_end: got cred=%0d cerr=%b occ=%0d expected 8/0/0",
                credit_count_2, credit_err_2, occupancy_2);
        end
    endtask

    task automatic test_reset_midstream();
        int late = 0;
        test_reset();
        for (int i = 0; i < 14; i++) begin
            send_in = 1'b1; data_in = 64'(i); credit_in = (i == 13);
            tick();
        end
        send_in = 1'b0; credit_in = 1'b0;
        tick();
        n_checks++;
        if (occupancy_0 !== 4'd5 || occupancy_2 !== 4'd5 || send_out_0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got occ0=%0d occ2=%0d send0=%b expected 5/5/1",
                occupancy_0, occupancy_2, send_out_0);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({send_out_0, send_out_2, credit_out_0, credit_out_2} !== 4'b0 ||
            occupancy_2 !== 4'd0 || credit_count_2 !== 4'd8 ||
            {overflow_err_2, credit_err_2, overflow_err_0, credit_err_0} !== 4'b0) begin
            n_fail++; $display("FAIL mid_reset: got send=%b%b credit=%b%b occ=%0d cred=%0d expected 00/00/0/8",
                send_out_0, send_out_2, credit_out_0, credit_out_2, occupancy_2, credit_count_2);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (send_out_2 || credit_out_2 || send_out_0 || credit_out_0) late++;
        end
        n_checks++;
        if (late != 0) begin
            n_fail++; $display("FAIL mid_discard: got %0d late strobes expected 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_credit_exhaustion();
        test_overflow();
        test_reset();
        test_simultaneous();
        test_reset();
        test_credit_err();
        test_reset();
        test_pipeline();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_link_relay.md
Name: noc_link_relay

Overview:
- Credit-terminating relay stage placed on a router-to-router link, between one router output port (data/dest/is_tail/send out, credit in) and the neighbouring router input port.
- Buffers incoming flits in a local FIFO and returns credits upstream as flits leave that FIFO.
- Keeps its own credit counter for the downstream router and forwards flits through an optional register pipeline.
- Lets long or retimed links close timing without deepening router flit buffers. Packet-agnostic: is_tail passes through unchanged.

Parameters:
- FLIT_WIDTH, 64, flit payload width.
- DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH).
- BUFFER_DEPTH, 8, relay FIFO depth; equals the credit count the upstream router is reset with (its FLIT_BUFFER_DEPTH). Power of two, ≥2.
- DOWNSTREAM_CREDITS, 8, credits held toward the downstream router at reset (its FLIT_BUFFER_DEPTH).
- OUT_PIPELINE, 0, extra forward register stages after the output register, 0..4.
- CNT_WIDTH, $clog2(max(BUFFER_DEPTH,DOWNSTREAM_CREDITS)+1), counter width. Derived; do not override.

Ports:
- clk_noc  in  1  NoC clock.
- rst_n  in  1  synchronous active-low reset.
- data_in  in  FLIT_WIDTH  upstream flit data.
- dest_in  in  DEST_WIDTH  upstream flit destination.
- is_tail_in  in  1  upstream tail marker.
- send_in  in  1  upstream flit valid, one flit per cycle.
- credit_out  out  1  one-cycle credit pulse to upstream.
- data_out  out  FLIT_WIDTH  downstream flit data.
- dest_out  out  DEST_WIDTH  downstream destination.
- is_tail_out  out  1  downstream tail marker.
- send_out  out  1  downstream flit valid.
- credit_in  in  1  credit pulse from downstream.
- occupancy  out  CNT_WIDTH  FIFO entry count.
- credit_count  out  CNT_WIDTH  credits available toward downstream.
- overflow_err  out  1  sticky; a flit arrived with no FIFO room.
- credit_err  out  1  sticky; credit_in arrived with the counter already at DOWNSTREAM_CREDITS.

Behaviour:
- Clocking and reset: one clock (clk_noc); rst_n is synchronous and active-low.
- Reset values: send_out, credit_out, data_out, dest_out, is_tail_out, all pipeline registers, occupancy, overflow_err and credit_err are 0. credit_count is DOWNSTREAM_CREDITS. FIFO is empty.
- Write: when send_in=1, {data,dest,is_tail} is written if occupancy < BUFFER_DEPTH, or if a pop occurs in the same cycle (full + pop + write leaves occupancy unchanged).
- Overflow: otherwise the flit is dropped, overflow_err is set, and no state changes.
- Pop: in any cycle with FIFO not empty and credit_count ≠ 0. The head flit is loaded into the output register and credit_count is decremented.
- Latency and throughput: send_in high in cycle n gives send_out high in cycle n+2+OUT_PIPELINE at the earliest. Throughput is 1 flit/cycle while credits last.
- Output hold: when there is no pop, stage-0 send is 0 and the data/dest/tail registers hold their previous value. Pipeline stages shift every cycle (no stall); send is carried per stage.
- credit_out: the registered pop strobe. A pop in cycle m gives credit_out=1 in cycle m+1, exactly one pulse per popped flit. No credits are issued for dropped flits.
- Credit counter update:
  - credit_in only: +1.
  - pop only: −1.
  - both in the same cycle: unchanged.
  - credit_in with count = DOWNSTREAM_CREDITS and no pop: saturate and set credit_err.
- Ordering: strict FIFO, and flits are never reordered or duplicated.
- Reset mid-stream: all buffered and in-pipeline flits are discarded and no credits are returned for them. The relay is reset together with both neighbouring routers from the same synchronised reset.
- Error flags clear only on reset.

Decomposition:
- Package noc_link_pkg holds the default FLIT_WIDTH/DEST_WIDTH constants, the OUT_PIPELINE maximum, and a clog2-based counter-width function.
- One sub-module, noc_link_fifo: synchronous FIFO with push/pop/full/empty/count and simultaneous push+pop when full. Storage is {is_tail, dest, data}.
- Credit counter, output register, pipeline and error flags are in the top level.

Test Plan:
- Single flit, OUT_PIPELINE=0: send_in in cycle 5 with data 0xA5A5_0000_0000_0001, dest 6'h0B, tail=1 → send_out=1 in cycle 7 with identical fields, credit_out=1 in cycle 7, credit_count 8→7.
- Credit exhaustion: 12 back-to-back flits with no credit_in → exactly 8 send_out, 8 credit_out pulses, occupancy=4, credit_count=0. Then 4 credit_in pulses → the remaining 4 flits drain in order, occupancy=0.
- Overflow: credit_count=0, occupancy=8, a 9th send_in → flit dropped, overflow_err=1, occupancy stays 8, no credit_out.
- Simultaneous events: credit_count=1 with a pop and credit_in in the same cycle → credit_count stays 1, and the next cycle pops again. Separately, credit_in at count=8 → credit_err=1, count stays 8.
- OUT_PIPELINE=2: send_in in cycle 10 → send_out in cycle 14. A 16-flit burst with ample credits → 16 consecutive send_out cycles.
- Reset mid-stream: rst_n low for 1 cycle with occupancy=5 and flits in the pipeline → the following cycle has send_out=0, credit_out=0, occupancy=0, credit_count=8, both error flags 0.
